wdt_win: RTL
============

Name: wdt_win

Overview:
- Parametrised, windowed watchdog; the next generation of the SoC watchdog.
- Sits on the peripheral register bus beside the reset generator.
- Adds a cycle prescaler, a key-protected kick and an early-warning interrupt ahead of timeout.
- Adds a lock bit and cause reporting. Drives the system reset request on expiry.

Parameters:
- NBIT, 32, data/counter width; must be >= 16.
- PRESC_W, 8, prescaler width; CTRL[8+PRESC_W-1:8] holds PRESC.
- KICK_KEY, 32'hC0DE_5AFE (truncated to NBIT), the only value accepted as a valid kick.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- addr_in  in  5  byte address; word index addr_in[4:2], bits [1:0] ignored
- wd_din  in  NBIT  write data
- wd_req  in  1  bus request
- wd_we  in  1  write enable; 0 = read
- wd_dout  out  NBIT  read data, registered
- wd_irq  out  1  early-warning interrupt, level
- wd_to  out  1  timeout flag, sticky
- rst_req_o  out  1  system reset request

Behaviour:
- Clock/reset: clk_i is the only clock. rstn_i is an asynchronous active-low reset on every flop.
- Registers (word offsets):
  - 0x00 CTRL: [0]EN, [1]LOCK (set-only), [8+:PRESC_W]PRESC.
  - 0x04 LOAD.
  - 0x08 WARN.
  - 0x0C KICK on write; current cnt on read.
  - 0x10 WIN.
  - 0x14 STATUS (read-only): [1:0]state, [2]irq, [3]to, [4]lock, [5]early-kick cause, [6]bad-key cause.
  - Unmapped offsets: reads return 0, writes ignored.
- Reset values: CTRL=0, LOAD=all-ones, WARN=0, WIN=all-ones, cnt=0, prescaler=0, state=IDLE. wd_dout, wd_irq, wd_to, rst_req_o = 0.
- Reads: wd_dout is valid the cycle after wd_req & ~wd_we, and holds until the next read.
- LOCK=1: writes to CTRL, LOAD, WARN and WIN are ignored. LOCK is cleared only by rstn_i. KICK writes still act.
- Prescaler: one tick every PRESC+1 cycles. It clears on a valid kick and on entry to RUN.
- States: IDLE(0), RUN(1), WARN(2), EXPIRED(3).
- IDLE -> RUN: CTRL write with EN=1; cnt<=LOAD on the next cycle.
- RUN/WARN: cnt decrements by 1 per tick and saturates at 0.
- RUN -> WARN: when WARN!=0 and cnt<=WARN; wd_irq=1.
- RUN/WARN -> EXPIRED: when cnt==0.
- RUN/WARN -> IDLE: CTRL write with EN=0 (only possible while unlocked); cnt holds its value, wd_irq=0.
- Valid kick (KICK write == KICK_KEY) in RUN/WARN: cnt<=LOAD, state=RUN, wd_irq=0, prescaler cleared.
- KICK write != KICK_KEY in RUN/WARN: EXPIRED next cycle; bad-key cause=1.
- Kick in IDLE or EXPIRED: no effect.
- EXPIRED: wd_to=1 and rst_req_o=1 held until rstn_i. wd_irq cleared. All writes are ignored except read access.
- Priority: a bus write in cycle N takes priority over the expiry/warn condition evaluated in cycle N. A valid kick in the same cycle as cnt==0 therefore reloads.
- LOAD=0 with EN set: EXPIRED two cycles after the CTRL write.
- Causes are sticky until rstn_i.

Optional Feature:
- Macro: WDT_WINDOW_EN.
- Defined: a valid kick while cnt > WIN is an early kick -> EXPIRED next cycle, early-kick cause=1. WIN=all-ones leaves the window always open.
- Undefined: WIN is not implemented (reads 0, writes ignored), early-kick cause is tied to 0, and all valid kicks are accepted.

Decomposition:
- Shared package wdt_pkg holds:
  - the state encoding constants;
  - register word offsets;
  - CTRL and STATUS bit positions;
  - the default KICK_KEY.
- One sub-module, wdt_prescaler: PRESC_W counter with clear input and tick output.
- Register file, FSM and counter live in wdt_win.

Test Plan:
- LOAD=10, PRESC=0, write CTRL EN=1 in cycle N -> cnt=10 at N+1, cnt=0 at N+11, wd_to=rst_req_o=1 at N+12, STATUS.state=3.
- LOAD=100, WARN=20, PRESC=3 -> wd_irq rises when cnt=20 (~320 cycles after enable); valid kick -> wd_irq=0, cnt=100, state RUN.
- Running, KICK write 32'h1234_5678 -> EXPIRED next cycle, STATUS[6]=1, wd_to=1; a later valid kick has no effect.
- Set LOCK, then write CTRL EN=0 and LOAD=5 -> both ignored, state remains RUN, LOAD readback unchanged.
- WDT_WINDOW_EN defined, LOAD=50, WIN=10:
  - kick at cnt=30 -> EXPIRED, STATUS[5]=1;
  - after rstn_i, kick at cnt=8 -> reload to 50.
- Valid kick written in the cycle cnt==0 -> reload wins, no timeout; assert rstn_i mid-RUN -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared definitions for the windowed watchdog: state encoding, register map,
// CTRL/STATUS bit positions and the default kick key.
package wdt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WARN    = 2'd2,
        ST_EXPIRED = 2'd3
    } wdt_state_e;

    // Word offsets (addr[4:2])
    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_LOAD   = 3'd1;
    localparam logic [2:0] OFF_WARN   = 3'd2;
    localparam logic [2:0] OFF_KICK   = 3'd3;
    localparam logic [2:0] OFF_WIN    = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_LOCK  = 1;
    localparam int CTRL_PRESC = 8;

    localparam int STAT_STATE  = 0;
    localparam int STAT_IRQ    = 2;
    localparam int STAT_TO     = 3;
    localparam int STAT_LOCK   = 4;
    localparam int STAT_EARLY  = 5;
    localparam int STAT_BADKEY = 6;

    localparam logic [31:0] KICK_KEY_DEF = 32'hC0DE_5AFE;

endpackage

// File: rtl/wdt_prescaler.sv
// Cycle prescaler: tick is high for one cycle out of every presc+1 while clr is low.
module wdt_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt;

    // >= rather than == so a PRESC lowered mid-count still ticks promptly
    assign tick = (pcnt >= presc);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pcnt <= '0;
        end else if (clr || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/wdt_win.sv
// Windowed watchdog with prescaler, keyed kick, early warning, lock and cause reporting.
// Define WDT_WINDOW_EN to implement the WIN register and early-kick detection.
module wdt_win
    import wdt_pkg::*;
#(
    parameter int              NBIT     = 32,
    parameter int              PRESC_W  = 8,
    parameter logic [NBIT-1:0] KICK_KEY = NBIT'(KICK_KEY_DEF)
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [4:0]      addr_in,
    input  logic [NBIT-1:0] wd_din,
    input  logic            wd_req,
    input  logic            wd_we,
    output logic [NBIT-1:0] wd_dout,
    output logic            wd_irq,
    output logic            wd_to,
    output logic            rst_req_o
);

    wdt_state_e         state;
    logic [NBIT-1:0]    cnt, load_q, warn_q, rdata;
    logic [PRESC_W-1:0] presc_q;
    logic               en_q, lock_q, cause_early, cause_bad;
    logic [2:0]         widx;
    logic               wr, rd, running, cfg_wr, ctrl_wr, kick_wr, key_ok, early;
    logic               kick_ok, kick_bad, kick_early, stop, expire, tick, addr_unused;

    assign widx        = addr_in[4:2];
    assign addr_unused = ^addr_in[1:0];
    assign wr          = wd_req & wd_we;
    assign rd          = wd_req & ~wd_we;
    assign running     = (state == ST_RUN) || (state == ST_WARN);
    assign cfg_wr      = wr && !lock_q && (state != ST_EXPIRED);
    assign ctrl_wr     = cfg_wr && (widx == OFF_CTRL);
    assign kick_wr     = wr && (widx == OFF_KICK) && running;
    assign key_ok      = (wd_din == KICK_KEY);

`ifdef WDT_WINDOW_EN
    logic [NBIT-1:0] win_q;
    assign early = (cnt > win_q);
`else
    assign early = 1'b0;
`endif

    assign kick_ok    = kick_wr & key_ok & ~early;
    assign kick_bad   = kick_wr & ~key_ok;
    assign kick_early = kick_wr & key_ok & early;
    assign stop       = ctrl_wr & ~wd_din[CTRL_EN] & running;
    // Bus writes win over the count-reached-zero condition of the same cycle
    assign expire     = running & ~kick_ok & (kick_bad | kick_early | (~stop & (cnt == '0)));

    wdt_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr    (~running | kick_ok),
        .presc  (presc_q),
        .tick   (tick)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            en_q    <= 1'b0;
            lock_q  <= 1'b0;
            presc_q <= '0;
            load_q  <= '1;
            warn_q  <= '0;
`ifdef WDT_WINDOW_EN
            win_q   <= '1;
`endif
        end else if (cfg_wr) begin
            case (widx)
                OFF_CTRL: begin
                    en_q    <= wd_din[CTRL_EN];
                    lock_q  <= lock_q | wd_din[CTRL_LOCK];
                    presc_q <= wd_din[CTRL_PRESC +: PRESC_W];
                end
                OFF_LOAD: load_q <= wd_din;
                OFF_WARN: warn_q <= wd_din;
`ifdef WDT_WINDOW_EN
                OFF_WIN:  win_q  <= wd_din;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            wd_irq      <= 1'b0;
            wd_to       <= 1'b0;
            rst_req_o   <= 1'b0;
            cause_early <= 1'b0;
            cause_bad   <= 1'b0;
        end else begin
            if (kick_bad)   cause_bad   <= 1'b1;
            if (kick_early) cause_early <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (ctrl_wr && wd_din[CTRL_EN]) begin
                        state <= ST_RUN;
                        cnt   <= load_q;
                    end
                end
                ST_RUN, ST_WARN: begin
                    if (kick_ok) begin
                        state  <= ST_RUN;
                        cnt    <= load_q;
                        wd_irq <= 1'b0;
                    end else if (expire) begin
                        state     <= ST_EXPIRED;
                        wd_irq    <= 1'b0;
                        wd_to     <= 1'b1;
                        rst_req_o <= 1'b1;
                    end else if (stop) begin
                        state  <= ST_IDLE;
                        wd_irq <= 1'b0;
                    end else begin
                        if (tick) cnt <= cnt - 1'b1;
                        if (state == ST_RUN && warn_q != '0 && cnt <= warn_q) begin
                            state  <= ST_WARN;
                            wd_irq <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rdata = '0;
        case (widx)
            OFF_CTRL: begin
                rdata[CTRL_EN]                = en_q;
                rdata[CTRL_LOCK]              = lock_q;
                rdata[CTRL_PRESC +: PRESC_W]  = presc_q;
            end
            OFF_LOAD: rdata = load_q;
            OFF_WARN: rdata = warn_q;
            OFF_KICK: rdata = cnt;
`ifdef WDT_WINDOW_EN
            OFF_WIN:  rdata = win_q;
`endif
            OFF_STATUS: begin
                rdata[STAT_STATE +: 2] = state;
                rdata[STAT_IRQ]        = wd_irq;
                rdata[STAT_TO]         = wd_to;
                rdata[STAT_LOCK]       = lock_q;
                rdata[STAT_EARLY]      = cause_early;
                rdata[STAT_BADKEY]     = cause_bad;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wd_dout <= '0;
        end else if (rd) begin
            wd_dout <= rdata;
        end
    end

endmodule
